// File: rtl/cnn_acc_pkg.sv
// rtl/cnn_acc_pkg.sv - shared state encoding and default widths for the accumulator sequencer
package cnn_acc_pkg;

  // Default widths: products per output and output pixels per layer
  localparam int TERM_W_DEF = 12;
  localparam int OUT_W_DEF  = 16;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DONE  = 2'd3
  } acc_state_t;

endpackage

// File: rtl/accum_term_counter.sv
// rtl/accum_term_counter.sv - wrap-at-limit up-counter with first/last flags
module accum_term_counter #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         is_first,
  output logic         is_last
);

  // limit is a count of positions (always >= 1 when enabled), so the last position is limit-1
  assign is_first = (count == '0);
  assign is_last  = (count == (limit - W'(1)));

  // Count enabled events, wrapping to zero after the last position; clear wins over en
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (en) begin
      if (is_last) begin
        count <= '0;
      end else begin
        count <= count + W'(1);
      end
    end
  end

endmodule

// File: rtl/accum_sequencer.sv
// rtl/accum_sequencer.sv - sequences one accumulator lane and hands finished sums downstream
module accum_sequencer #(
  parameter int TERM_W = cnn_acc_pkg::TERM_W_DEF,
  parameter int OUT_W  = cnn_acc_pkg::OUT_W_DEF
) (
  input  logic              clk,
  input  logic              layer_reset,
  input  logic              cfg_valid,
  input  logic [TERM_W-1:0] cfg_terms,
  input  logic [OUT_W-1:0]  cfg_outputs,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic              stage_finish,
  output logic              adder_en,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [OUT_W-1:0]  out_index,
  output logic              busy,
  output logic              layer_done
);

  import cnn_acc_pkg::*;

  acc_state_t        state;
  acc_state_t        state_next;

  // Layer configuration captured at start; all compares use these, never the live cfg inputs
  logic [TERM_W-1:0] terms_lat;
  logic [OUT_W-1:0]  outputs_lat;
  logic              latch_cfg;

  logic              fire;
  logic              out_en;

  logic [TERM_W-1:0] term_cnt;
  logic              term_first;
  logic              term_last;
  logic              term_clear;

  logic              out_first;
  logic              out_last;
  logic              out_clear;

  logic              unused_bits;

  assign fire = prod_valid & prod_ready;

  // The first term of every output loads the adder; every later term accumulates
  assign stage_finish = fire & term_first;
  assign adder_en     = fire & ~term_first;

  assign sum_valid  = (state == ST_HOLD);
  assign busy       = (state == ST_ACCUM) || (state == ST_HOLD);
  assign layer_done = (state == ST_DONE);

  // Counters restart from zero whenever a layer is not in progress
  assign term_clear = layer_reset || (state == ST_IDLE);
  assign out_clear  = layer_reset || (state == ST_IDLE) || (state == ST_DONE);

  // Only the flags of the term counter and the count of the output counter are needed
  assign unused_bits = ^{term_cnt, out_first};

  accum_term_counter #(
    .W (TERM_W)
  ) u_term_cnt (
    .clk      (clk),
    .clear    (term_clear),
    .en       (fire),
    .limit    (terms_lat),
    .count    (term_cnt),
    .is_first (term_first),
    .is_last  (term_last)
  );

  accum_term_counter #(
    .W (OUT_W)
  ) u_out_cnt (
    .clk      (clk),
    .clear    (out_clear),
    .en       (out_en),
    .limit    (outputs_lat),
    .count    (out_index),
    .is_first (out_first),
    .is_last  (out_last)
  );

  // State register and layer configuration capture
  always_ff @(posedge clk) begin
    if (layer_reset) begin
      state       <= ST_IDLE;
      terms_lat   <= TERM_W'(1);
      outputs_lat <= '0;
    end else begin
      state <= state_next;
      if (latch_cfg) begin
        // A zero term count would never reach its last term, so it runs as a single term
        terms_lat   <= (cfg_terms == '0) ? TERM_W'(1) : cfg_terms;
        outputs_lat <= cfg_outputs;
      end
    end
  end

  // Next-state, product handshake and output-advance decisions
  always_comb begin
    state_next = state;
    prod_ready = 1'b0;
    out_en     = 1'b0;
    latch_cfg  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cfg_valid) begin
          latch_cfg  = 1'b1;
          state_next = (cfg_outputs == '0) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        prod_ready = 1'b1;
        if (prod_valid && term_last) begin
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (sum_ready) begin
          out_en = 1'b1;
          if (out_last) begin
            state_next = ST_DONE;
          end else begin
            // Result leaves this cycle, so the next output's first product may enter now
            prod_ready = 1'b1;
            if (prod_valid && term_last) begin
              state_next = ST_HOLD;
            end else begin
              state_next = ST_ACCUM;
            end
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_accum_sequencer.sv
// tb/tb_accum_sequencer.sv - directed self-checking bench for accum_sequencer
module tb_accum_sequencer;

  logic        clk;
  logic        layer_reset;
  logic        cfg_valid;
  logic [11:0] cfg_terms;
  logic [15:0] cfg_outputs;
  logic        prod_valid;
  logic        prod_ready;
  logic        stage_finish;
  logic        adder_en;
  logic        sum_valid;
  logic        sum_ready;
  logic [15:0] out_index;
  logic        busy;
  logic        layer_done;

  int checks;
  int failures;

  // Bench-side adder: addend is the running product number, starting at 1 per layer
  int sum_m;
  int addend_m;

  // Event tallies kept by the monitor
  int   cyc;
  int   fire_n;
  int   sf_n;
  int   ae_n;
  int   both_n;
  int   en_nofire_n;
  int   sv_late_n;
  int   done_n;
  int   done_cyc;
  int   res_n;
  int   res_sum [8];
  int   res_idx [8];
  int   res_cyc [8];
  logic mon_fire;
  logic fire_prev;
  logic sv_prev;

  accum_sequencer #(
    .TERM_W (12),
    .OUT_W  (16)
  ) dut (
    .clk          (clk),
    .layer_reset  (layer_reset),
    .cfg_valid    (cfg_valid),
    .cfg_terms    (cfg_terms),
    .cfg_outputs  (cfg_outputs),
    .prod_valid   (prod_valid),
    .prod_ready   (prod_ready),
    .stage_finish (stage_finish),
    .adder_en     (adder_en),
    .sum_valid    (sum_valid),
    .sum_ready    (sum_ready),
    .out_index    (out_index),
    .busy         (busy),
    .layer_done   (layer_done)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder model driven by the DUT's load/accumulate strobes
  always @(posedge clk) begin
    if (layer_reset) begin
      sum_m    <= 0;
      addend_m <= 1;
    end else begin
      if (stage_finish) sum_m <= addend_m;
      else if (adder_en) sum_m <= sum_m + addend_m;
      if (prod_valid && prod_ready) addend_m <= addend_m + 1;
    end
  end

  // Monitor: tally handshake events on the falling edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    mon_fire = prod_valid && prod_ready;
    if (layer_reset) begin
      fire_n = 0; sf_n = 0; ae_n = 0; both_n = 0; en_nofire_n = 0;
      sv_late_n = 0; done_n = 0; done_cyc = 0; res_n = 0;
    end else begin
      if (mon_fire) fire_n = fire_n + 1;
      if (stage_finish) sf_n = sf_n + 1;
      if (adder_en) ae_n = ae_n + 1;
      if (stage_finish && adder_en) both_n = both_n + 1;
      if ((stage_finish || adder_en) && !mon_fire) en_nofire_n = en_nofire_n + 1;
      if (sum_valid && !sv_prev && !fire_prev) sv_late_n = sv_late_n + 1;
      if (layer_done) begin
        done_n = done_n + 1;
        done_cyc = cyc;
      end
      if (sum_valid && sum_ready && res_n < 8) begin
        res_sum[res_n] = sum_m;
        res_idx[res_n] = int'(out_index);
        res_cyc[res_n] = cyc;
        res_n = res_n + 1;
      end
    end
    sv_prev = sum_valid;
    fire_prev = mon_fire;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    layer_reset = 1'b1;
    cfg_valid   = 1'b0;
    prod_valid  = 1'b0;
    sum_ready   = 1'b0;
    step();
    step();
    layer_reset = 1'b0;
  endtask

  task automatic start(input int terms, input int outs);
    cfg_terms   = 12'(terms);
    cfg_outputs = 16'(outs);
    cfg_valid   = 1'b1;
    step();
    cfg_valid   = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_n == 0; i++) step();
    step();
    step();
  endtask

  task automatic check_quiet(input string p);
    check_eq({p, "_prod_ready"}, int'(prod_ready), 0);
    check_eq({p, "_stage_finish"}, int'(stage_finish), 0);
    check_eq({p, "_adder_en"}, int'(adder_en), 0);
    check_eq({p, "_sum_valid"}, int'(sum_valid), 0);
    check_eq({p, "_out_index"}, int'(out_index), 0);
    check_eq({p, "_busy"}, int'(busy), 0);
    check_eq({p, "_layer_done"}, int'(layer_done), 0);
  endtask

  // terms=9, outputs=2, always ready: sums 1..9=45 and 10..18=126
  task automatic run_nine_by_two(input string p);
    prod_valid = 1'b1;
    sum_ready  = 1'b1;
    start(9, 2);
    wait_done(200);
    check_eq({p, "_fires"}, fire_n, 18);
    check_eq({p, "_stage_finish"}, sf_n, 2);
    check_eq({p, "_adder_en"}, ae_n, 16);
    check_eq({p, "_both_high"}, both_n, 0);
    check_eq({p, "_sv_late"}, sv_late_n, 0);
    check_eq({p, "_results"}, res_n, 2);
    check_eq({p, "_sum0"}, res_sum[0], 45);
    check_eq({p, "_sum1"}, res_sum[1], 126);
    check_eq({p, "_idx1"}, res_idx[1], 1);
    check_eq({p, "_done"}, done_n, 1);
    check_eq({p, "_busy_end"}, int'(busy), 0);
    prod_valid = 1'b0;
    sum_ready  = 1'b0;
  endtask

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int exp3 [3];
    exp3 = '{6, 15, 24};
    checks = 0;
    failures = 0;
    cyc = 0;
    sv_prev = 1'b0;
    fire_prev = 1'b0;
    cfg_terms = '0;
    cfg_outputs = '0;

    // Reset state
    do_reset();
    check_quiet("reset");

    // Scenario 1: back-to-back 9-term outputs
    run_nine_by_two("s1");

    // Scenario 2: toggling product valid, single 4-term output -> 10
    do_reset();
    sum_ready = 1'b1;
    start(4, 1);
    for (int i = 0; i < 60 && done_n == 0; i++) begin
      prod_valid = (i % 2 == 0);
      step();
    end
    prod_valid = 1'b0;
    step();
    check_eq("s2_fires", fire_n, 4);
    check_eq("s2_adder_en", ae_n, 3);
    check_eq("s2_en_nofire", en_nofire_n, 0);
    check_eq("s2_sv_late", sv_late_n, 0);
    check_eq("s2_sum", res_sum[0], 10);
    check_eq("s2_done", done_n, 1);

    // Scenario 3: downstream stalls 5 cycles on every result
    do_reset();
    prod_valid = 1'b1;
    sum_ready  = 1'b0;
    start(3, 3);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 40 && !sum_valid; i++) step();
      for (int j = 0; j < 5; j++) begin
        check_eq($sformatf("s3_sum_valid_%0d_%0d", k, j), int'(sum_valid), 1);
        check_eq($sformatf("s3_prod_ready_%0d_%0d", k, j), int'(prod_ready), 0);
        check_eq($sformatf("s3_sum_%0d_%0d", k, j), sum_m, exp3[k]);
        check_eq($sformatf("s3_index_%0d_%0d", k, j), int'(out_index), k);
        step();
      end
      sum_ready = 1'b1;
      step();
      sum_ready = 1'b0;
    end
    wait_done(40);
    check_eq("s3_results", res_n, 3);
    check_eq("s3_idx2", res_idx[2], 2);
    check_eq("s3_done", done_n, 1);
    prod_valid = 1'b0;

    // Scenario 4: single-term outputs stream with no bubbles
    do_reset();
    prod_valid = 1'b1;
    sum_ready  = 1'b1;
    start(1, 4);
    wait_done(60);
    check_eq("s4_stage_finish", sf_n, 4);
    check_eq("s4_adder_en", ae_n, 0);
    check_eq("s4_results", res_n, 4);
    check_eq("s4_sum3", res_sum[3], 4);
    check_eq("s4_idx3", res_idx[3], 3);
    check_eq("s4_back_to_back", res_cyc[3] - res_cyc[0], 3);
    check_eq("s4_done_latency", done_cyc - res_cyc[3], 1);
    check_eq("s4_done", done_n, 1);
    prod_valid = 1'b0;
    sum_ready  = 1'b0;

    // Scenario 5a: zero-output layer goes straight to a done pulse
    do_reset();
    prod_valid = 1'b1;
    start(5, 0);
    check_eq("s5_done_pulse", int'(layer_done), 1);
    check_eq("s5_busy_in_done", int'(busy), 0);
    check_eq("s5_prod_ready", int'(prod_ready), 0);
    step();
    check_eq("s5_done_one_cycle", int'(layer_done), 0);
    check_eq("s5_fires", fire_n, 0);
    prod_valid = 1'b0;

    // Scenario 5b: cfg while busy is ignored (terms=2, outputs=2 -> sums 3 and 7)
    do_reset();
    start(2, 2);
    check_eq("s5_busy", int'(busy), 1);
    start(7, 5);
    step();
    check_eq("s5_busy_after_cfg", int'(busy), 1);
    check_eq("s5_stall_fires", fire_n, 0);
    check_eq("s5_stall_index", int'(out_index), 0);
    prod_valid = 1'b1;
    sum_ready  = 1'b1;
    wait_done(60);
    check_eq("s5_fires_total", fire_n, 4);
    check_eq("s5_results", res_n, 2);
    check_eq("s5_sum1", res_sum[1], 7);
    check_eq("s5_done", done_n, 1);
    prod_valid = 1'b0;
    sum_ready  = 1'b0;

    // Scenario 6: abort mid-output, then a clean rerun
    do_reset();
    prod_valid = 1'b1;
    sum_ready  = 1'b1;
    start(9, 2);
    for (int i = 0; i < 40 && fire_n < 5; i++) step();
    layer_reset = 1'b1;
    step();
    layer_reset = 1'b0;
    prod_valid = 1'b0;
    sum_ready  = 1'b0;
    check_quiet("s6_abort");
    for (int i = 0; i < 5; i++) step();
    check_eq("s6_no_done", done_n, 0);
    run_nine_by_two("s6_rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
